// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: unit selects, operation codes and divider states.
package ex_pkg;

    localparam logic [2:0] SelLogic = 3'b001;
    localparam logic [2:0] SelShift = 3'b010;
    localparam logic [2:0] SelMove  = 3'b011;
    localparam logic [2:0] SelArith = 3'b100;
    localparam logic [2:0] SelMulDiv = 3'b101;

    localparam logic [7:0] OpOr    = 8'b00100101;
    localparam logic [7:0] OpAnd   = 8'b00100100;
    localparam logic [7:0] OpXor   = 8'b00100110;
    localparam logic [7:0] OpNor   = 8'b00100111;
    localparam logic [7:0] OpSrl   = 8'b00000010;
    localparam logic [7:0] OpSra   = 8'b00000011;
    localparam logic [7:0] OpSll   = 8'b01111100;
    localparam logic [7:0] OpAdd   = 8'b00100000;
    localparam logic [7:0] OpAddu  = 8'b00100001;
    localparam logic [7:0] OpSub   = 8'b00100010;
    localparam logic [7:0] OpSubu  = 8'b00100011;
    localparam logic [7:0] OpSlt   = 8'b00101010;
    localparam logic [7:0] OpSltu  = 8'b00101011;
    localparam logic [7:0] OpMfhi  = 8'b00010000;
    localparam logic [7:0] OpMthi  = 8'b00010001;
    localparam logic [7:0] OpMflo  = 8'b00010010;
    localparam logic [7:0] OpMtlo  = 8'b00010011;
    localparam logic [7:0] OpMult  = 8'b00011000;
    localparam logic [7:0] OpMultu = 8'b00011001;
    localparam logic [7:0] OpDiv   = 8'b00011010;
    localparam logic [7:0] OpDivu  = 8'b00011011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up applied on the way out.
module div_iter
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic              cancel,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [DATA_W-1:0] dividend_mag, divisor_mag;
    logic [DATA_W:0]   trial_rem, trial_diff;

    assign dividend_mag = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign trial_rem  = {rem_q, quo_q[DATA_W-1]};
    assign trial_diff = trial_rem - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == StIdle && start) begin
            cnt_d = '0;
            if (divisor == '0) begin
                // Divide by zero bypasses the sign fix-up entirely.
                quo_d     = '1;
                rem_d     = dividend;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else begin
                quo_d     = dividend_mag;
                rem_d     = '0;
                dvs_d     = divisor_mag;
                neg_quo_d = is_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                neg_rem_d = is_signed && dividend[DATA_W-1];
            end
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial_diff[DATA_W]) begin
                rem_d = trial_diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = trial_rem[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        idle      = (state_q == StIdle);
        busy      = (state_q == StRun);
        done      = (state_q == StDone) && !cancel;
        quotient  = neg_quo_q ? -quo_q : quo_q;
        remainder = neg_rem_q ? -rem_q : rem_q;
    end

endmodule

// File: rtl/ex_muldiv.sv
// OpenMIPS execute stage: combinational ALU, single-cycle multiplier, HI/LO registers
// and a stalling iterative divider.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        alu_sel,
    input  logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] src_data1,
    input  logic [DATA_W-1:0] src_data2,
    input  logic [4:0]        wr_addr,
    input  logic              wr_en,
    input  logic              div_cancel,
    output logic [4:0]        out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_en,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              ovf,
    output logic              stall_req
);

    logic [DATA_W-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic [SHAMT_W-1:0]       shamt;
    logic signed [DATA_W-1:0] sra_res;
    logic [DATA_W-1:0]        sum, diff, result;
    logic                     add_ovf, sub_ovf, slt, sltu, arith_ovf, kill_wr;
    logic [2*DATA_W-1:0]      mul_a, mul_b, product;
    logic                     issue_mul, issue_div, issue_mthi, issue_mtlo;
    logic                     div_idle, div_busy, div_done;
    logic [DATA_W-1:0]        div_quo, div_rem;

    assign shamt   = src_data1[SHAMT_W-1:0];
    assign sra_res = $signed(src_data2) >>> shamt;
    assign sum     = src_data1 + src_data2;
    assign diff    = src_data1 - src_data2;
    assign add_ovf = (src_data1[DATA_W-1] == src_data2[DATA_W-1]) &&
                     (sum[DATA_W-1] != src_data1[DATA_W-1]);
    assign sub_ovf = (src_data1[DATA_W-1] != src_data2[DATA_W-1]) &&
                     (diff[DATA_W-1] != src_data1[DATA_W-1]);
    assign slt     = $signed(src_data1) < $signed(src_data2);
    assign sltu    = src_data1 < src_data2;

    assign issue_mul  = (alu_sel == SelMulDiv) && (alu_op == OpMult || alu_op == OpMultu);
    assign issue_div  = (alu_sel == SelMulDiv) && (alu_op == OpDiv || alu_op == OpDivu);
    assign issue_mthi = (alu_sel == SelMove) && (alu_op == OpMthi);
    assign issue_mtlo = (alu_sel == SelMove) && (alu_op == OpMtlo);

    // Sign-extend to full product width so one unsigned multiply serves both forms.
    assign mul_a   = (alu_op == OpMult) ? {{DATA_W{src_data1[DATA_W-1]}}, src_data1}
                                        : {{DATA_W{1'b0}}, src_data1};
    assign mul_b   = (alu_op == OpMult) ? {{DATA_W{src_data2[DATA_W-1]}}, src_data2}
                                        : {{DATA_W{1'b0}}, src_data2};
    assign product = mul_a * mul_b;

    div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (issue_div),
        .is_signed (alu_op == OpDiv),
        .cancel    (div_cancel),
        .dividend  (src_data1),
        .divisor   (src_data2),
        .idle      (div_idle),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        result    = '0;
        arith_ovf = 1'b0;
        kill_wr   = 1'b0;
        case (alu_sel)
            SelLogic: begin
                case (alu_op)
                    OpOr:    result = src_data1 | src_data2;
                    OpAnd:   result = src_data1 & src_data2;
                    OpXor:   result = src_data1 ^ src_data2;
                    OpNor:   result = ~(src_data1 | src_data2);
                    default: result = '0;
                endcase
            end
            SelShift: begin
                case (alu_op)
                    OpSrl:   result = src_data2 >> shamt;
                    OpSra:   result = sra_res;
                    OpSll:   result = src_data2 << shamt;
                    default: result = '0;
                endcase
            end
            SelMove: begin
                case (alu_op)
                    OpMfhi:         result = hi_q;
                    OpMflo:         result = lo_q;
                    OpMthi, OpMtlo: kill_wr = 1'b1;
                    default:        result = '0;
                endcase
            end
            SelArith: begin
                case (alu_op)
                    OpAdd: begin
                        result    = sum;
                        arith_ovf = add_ovf;
                    end
                    OpAddu: result = sum;
                    OpSub: begin
                        result    = diff;
                        arith_ovf = sub_ovf;
                    end
                    OpSubu:  result = diff;
                    OpSlt:   result = {{(DATA_W-1){1'b0}}, slt};
                    OpSltu:  result = {{(DATA_W-1){1'b0}}, sltu};
                    default: result = '0;
                endcase
            end
            SelMulDiv: kill_wr = 1'b1;
            default:   result = '0;
        endcase
    end

    always_comb begin
        out_addr  = wr_addr;
        out_data  = reset ? result : '0;
        out_en    = reset && wr_en && !kill_wr && !arith_ovf;
        ovf       = reset && arith_ovf;
        stall_req = reset && (div_cancel ? (div_idle && issue_div)
                                         : ((issue_div && !div_done) || div_busy));
        hi_o      = hi_q;
        lo_o      = lo_q;
    end

    // Division completion wins over a same-edge MULT/MT* write.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
        end else if (issue_mul) begin
            hi_d = product[2*DATA_W-1:DATA_W];
            lo_d = product[DATA_W-1:0];
        end else if (issue_mthi) begin
            hi_d = src_data1;
        end else if (issue_mtlo) begin
            lo_d = src_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

    localparam int unsigned W = 32;

    localparam logic [2:0] LogicSel = 3'b001;
    localparam logic [2:0] ShiftSel = 3'b010;
    localparam logic [2:0] MoveSel  = 3'b011;
    localparam logic [2:0] ArithSel = 3'b100;
    localparam logic [2:0] MdSel    = 3'b101;

    localparam logic [7:0] CodeOr    = 8'b00100101;
    localparam logic [7:0] CodeAnd   = 8'b00100100;
    localparam logic [7:0] CodeXor   = 8'b00100110;
    localparam logic [7:0] CodeNor   = 8'b00100111;
    localparam logic [7:0] CodeSrl   = 8'b00000010;
    localparam logic [7:0] CodeSra   = 8'b00000011;
    localparam logic [7:0] CodeSll   = 8'b01111100;
    localparam logic [7:0] CodeAdd   = 8'b00100000;
    localparam logic [7:0] CodeAddu  = 8'b00100001;
    localparam logic [7:0] CodeSub   = 8'b00100010;
    localparam logic [7:0] CodeSubu  = 8'b00100011;
    localparam logic [7:0] CodeSlt   = 8'b00101010;
    localparam logic [7:0] CodeSltu  = 8'b00101011;
    localparam logic [7:0] CodeMfhi  = 8'b00010000;
    localparam logic [7:0] CodeMthi  = 8'b00010001;
    localparam logic [7:0] CodeMflo  = 8'b00010010;
    localparam logic [7:0] CodeMtlo  = 8'b00010011;
    localparam logic [7:0] CodeMult  = 8'b00011000;
    localparam logic [7:0] CodeMultu = 8'b00011001;
    localparam logic [7:0] CodeDiv   = 8'b00011010;
    localparam logic [7:0] CodeDivu  = 8'b00011011;

    logic         clk = 1'b0;
    logic         reset, wr_en, div_cancel, out_en, ovf, stall_req;
    logic [2:0]   alu_sel;
    logic [7:0]   alu_op;
    logic [W-1:0] src_data1, src_data2, out_data, hi_o, lo_o;
    logic [4:0]   wr_addr, out_addr;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  hi_m, lo_m;

    logic [10:0]  ops [0:19] = '{
        {LogicSel, CodeOr}, {LogicSel, CodeAnd}, {LogicSel, CodeXor}, {LogicSel, CodeNor},
        {ShiftSel, CodeSrl}, {ShiftSel, CodeSra}, {ShiftSel, CodeSll},
        {ArithSel, CodeAdd}, {ArithSel, CodeAddu}, {ArithSel, CodeSub},
        {ArithSel, CodeSubu}, {ArithSel, CodeSlt}, {ArithSel, CodeSltu},
        {MoveSel, CodeMfhi}, {MoveSel, CodeMflo}, {MoveSel, CodeMthi}, {MoveSel, CodeMtlo},
        {MdSel, CodeMult}, {MdSel, CodeMultu}, {3'b111, CodeAdd}
    };

    ex_muldiv #(
        .DATA_W (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_sel    (alu_sel),
        .alu_op     (alu_op),
        .src_data1  (src_data1),
        .src_data2  (src_data2),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .div_cancel (div_cancel),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_en     (out_en),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .ovf        (ovf),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alu_sel   = sel;
        alu_op    = op;
        src_data1 = a;
        src_data2 = b;
    endtask

    function automatic logic [31:0] ref_data(input logic [2:0] sel, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = a[4:0];
        ref_data = '0;
        if (sel == LogicSel) begin
            if (op == CodeOr)  ref_data = a | b;
            if (op == CodeAnd) ref_data = a & b;
            if (op == CodeXor) ref_data = a ^ b;
            if (op == CodeNor) ref_data = ~(a | b);
        end else if (sel == ShiftSel) begin
            if (op == CodeSrl) ref_data = b >> sh;
            if (op == CodeSra) ref_data = 32'(sb >>> sh);
            if (op == CodeSll) ref_data = b << sh;
        end else if (sel == ArithSel) begin
            if (op == CodeAdd || op == CodeAddu) ref_data = 32'(sa + sb);
            if (op == CodeSub || op == CodeSubu) ref_data = 32'(sa - sb);
            if (op == CodeSlt)  ref_data = {31'b0, sa < sb};
            if (op == CodeSltu) ref_data = {31'b0, a < b};
        end else if (sel == MoveSel) begin
            if (op == CodeMfhi) ref_data = hi_m;
            if (op == CodeMflo) ref_data = lo_m;
        end
    endfunction

    function automatic logic ref_ovf(input logic [2:0] sel, input logic [7:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
        longint r;
        ref_ovf = 1'b0;
        if (sel == ArithSel && (op == CodeAdd || op == CodeSub)) begin
            r = (op == CodeAdd) ? longint'($signed(a)) + longint'($signed(b))
                                : longint'($signed(a)) - longint'($signed(b));
            ref_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
    endfunction

    function automatic logic ref_en(input logic [2:0] sel, input logic [7:0] op,
                                    input logic [31:0] a, input logic [31:0] b, input logic en);
        ref_en = en && !ref_ovf(sel, op, a, b) && (sel != MdSel) &&
                 !(sel == MoveSel && (op == CodeMthi || op == CodeMtlo));
    endfunction

    // HI/LO effect of a non-divide instruction completing at the clock edge.
    task automatic ref_hilo(input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (sel == MdSel && op == CodeMult) begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (sel == MdSel && op == CodeMultu) begin
            p = {32'b0, a} * {32'b0, b};
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (sel == MoveSel && op == CodeMthi) begin
            hi_m = a;
        end else if (sel == MoveSel && op == CodeMtlo) begin
            lo_m = a;
        end
    endtask

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint qq, rr;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            qq = longint'($signed(a)) / longint'($signed(b));
            rr = longint'($signed(a)) % longint'($signed(b));
            q  = qq[31:0];
            r  = rr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic comb_exp(input string tag, input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_data, input logic exp_en, input logic exp_ovf);
        drive(sel, op, a, b);
        #1;
        if (!exp_ovf) check({tag, ".data"}, out_data, exp_data);
        check({tag, ".en"}, out_en, exp_en);
        check({tag, ".ovf"}, ovf, exp_ovf);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b);
        int cnt;
        logic [31:0] q, r;
        cnt = 0;
        drive(MdSel, sgn ? CodeDiv : CodeDivu, a, b);
        #1;
        while (stall_req && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #2;
        end
        check({tag, ".stall"}, cnt, (b == 0) ? 1 : W + 1);
        tick();
        drive(3'b000, 8'h00, 0, 0);
        #1;
        ref_div(sgn, a, b, q, r);
        hi_m = r;
        lo_m = q;
        check({tag, ".lo"}, lo_o, lo_m);
        check({tag, ".hi"}, hi_o, hi_m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        en, eo;

        reset = 1'b0; div_cancel = 1'b0; wr_en = 1'b0; wr_addr = 5'd0;
        drive(3'b000, 8'h00, 0, 0);
        hi_m = '0; lo_m = '0;
        tick(); tick();

        // Outputs held at zero while reset is low, even with a live instruction.
        drive(ArithSel, CodeAddu, 32'd5, 32'd6);
        wr_en = 1'b1; wr_addr = 5'd3;
        #1;
        check("rst.data", out_data, 0);
        check("rst.en", out_en, 0);
        check("rst.hi", hi_o, 0);
        check("rst.lo", lo_o, 0);
        drive(MdSel, CodeDiv, 32'd9, 32'd2);
        #1;
        check("rst.stall", stall_req, 0);
        drive(3'b000, 8'h00, 0, 0);
        tick();
        reset = 1'b1;

        comb_exp("add_ovf", ArithSel, CodeAdd, 32'h7FFFFFFF, 32'd1, 32'h0, 1'b0, 1'b1);
        comb_exp("addu", ArithSel, CodeAddu, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0);
        check("addu.addr", out_addr, 5'd3);
        comb_exp("sub_ovf", ArithSel, CodeSub, 32'h80000000, 32'd1, 32'h0, 1'b0, 1'b1);
        comb_exp("slt", ArithSel, CodeSlt, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0);
        comb_exp("sltu", ArithSel, CodeSltu, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        comb_exp("sra", ShiftSel, CodeSra, 32'd4, 32'h80000000, 32'hF8000000, 1'b1, 1'b0);
        comb_exp("srl", ShiftSel, CodeSrl, 32'd4, 32'h80000000, 32'h08000000, 1'b1, 1'b0);
        comb_exp("sll", ShiftSel, CodeSll, 32'd31, 32'd1, 32'h80000000, 1'b1, 1'b0);
        comb_exp("nor", LogicSel, CodeNor, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        comb_exp("badsel", 3'b111, CodeOr, 32'hFF, 32'hF0, 32'h0, 1'b1, 1'b0);

        comb_exp("mult", MdSel, CodeMult, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 1'b0);
        check("mult.stall", stall_req, 0);
        tick();
        comb_exp("mult.mfhi", MoveSel, CodeMfhi, 0, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("mult.lo", lo_o, 32'hFFFFFFFE);
        drive(MdSel, CodeMultu, 32'hFFFFFFFF, 32'd2);
        tick();
        comb_exp("multu.mfhi", MoveSel, CodeMfhi, 0, 0, 32'h00000001, 1'b1, 1'b0);
        check("multu.lo", lo_o, 32'hFFFFFFFE);
        hi_m = 32'h1; lo_m = 32'hFFFFFFFE;

        run_div("div7", 1'b1, 32'd7, 32'hFFFFFFFE);
        check("div7.lo_k", lo_o, 32'hFFFFFFFD);
        check("div7.hi_k", hi_o, 32'h00000001);
        run_div("divu0", 1'b0, 32'h12345678, 32'd0);
        check("divu0.lo_k", lo_o, 32'hFFFFFFFF);
        check("divu0.hi_k", hi_o, 32'h12345678);

        for (int i = 0; i < 60; i++) begin
            {sel, op} = ops[$urandom_range(0, 19)];
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) a = 32'h7FFFFFFF;
            en = 1'($urandom_range(0, 1));
            wr_en = en;
            wr_addr = 5'($urandom);
            drive(sel, op, a, b);
            #1;
            eo = ref_ovf(sel, op, a, b);
            if (!eo) check($sformatf("r%0d.data", i), out_data, ref_data(sel, op, a, b));
            check($sformatf("r%0d.en", i), out_en, ref_en(sel, op, a, b, en));
            check($sformatf("r%0d.ovf", i), ovf, eo);
            check($sformatf("r%0d.addr", i), out_addr, wr_addr);
            check($sformatf("r%0d.stall", i), stall_req, 0);
            ref_hilo(sel, op, a, b);
            tick();
            check($sformatf("r%0d.hi", i), hi_o, hi_m);
            check($sformatf("r%0d.lo", i), lo_o, lo_m);
        end

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 2) ? 32'd0 : ((i % 2 == 1) ? $urandom_range(1, 100) : $urandom);
            run_div($sformatf("rdiv%0d", i), 1'($urandom_range(0, 1)), a, b);
        end

        // Reset in the middle of a division.
        drive(MoveSel, CodeMthi, 32'hA5A5A5A5, 0);
        tick();
        drive(MoveSel, CodeMtlo, 32'h5A5A5A5A, 0);
        tick();
        drive(MdSel, CodeDiv, 32'd100, 32'd7);
        #1;
        check("rstmid.stall_issue", stall_req, 1);
        tick();
        repeat (9) tick();
        check("rstmid.stall_run", stall_req, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(3'b000, 8'h00, 0, 0);
        #1;
        hi_m = '0; lo_m = '0;
        check("rstmid.stall", stall_req, 0);
        check("rstmid.hi", hi_o, 0);
        check("rstmid.lo", lo_o, 0);

        // Cancel in RUN leaves HI/LO untouched.
        drive(MoveSel, CodeMthi, 32'h11112222, 0);
        tick();
        drive(MoveSel, CodeMtlo, 32'h33334444, 0);
        tick();
        hi_m = 32'h11112222; lo_m = 32'h33334444;
        drive(MdSel, CodeDivu, 32'd1000, 32'd3);
        tick();
        repeat (4) tick();
        div_cancel = 1'b1;
        #1;
        check("cancel.stall", stall_req, 0);
        tick();
        div_cancel = 1'b0;
        drive(3'b000, 8'h00, 0, 0);
        #1;
        check("cancel.stall_after", stall_req, 0);
        repeat (40) tick();
        check("cancel.hi", hi_o, hi_m);
        check("cancel.lo", lo_o, lo_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
